// File: rtl/aes_round_ctrl.sv
// Purpose : round sequencer for the AES round datapath; emits one-hot init/first/middle/last
//           round flags, latches plaintext/key on start and captures the ciphertext at the end.
// Latency : done pulses NUM_ROUNDS+3 cycles after a start is accepted (13 cycles for AES-128).
// Backpr. : no queueing; iStart is only sampled in IDLE, and a start is accepted in the done cycle.
// Optional: define AES_ROUND_CTRL_ABORT_EN to add iAbort/oAbortAck (cancel an operation in flight).
// Ports   : iClk/iRsn clock and synchronous active-high reset; iStart/iPlainText/iAesKey start
//           request and operands; iCpText datapath result; o*RoundFlag round phase; oPlainText/
//           oAesKey latched operands; oBusy/oDone status; oCpText result; oRoundCnt debug counter.
module aes_round_ctrl #(
  parameter int NUM_ROUNDS = 10,
  parameter int CNT_W      = 4
) (
  input  logic             iClk,
  input  logic             iRsn,
  input  logic             iStart,
  input  logic [127:0]     iPlainText,
  input  logic [127:0]     iAesKey,
  input  logic [127:0]     iCpText,
`ifdef AES_ROUND_CTRL_ABORT_EN
  input  logic             iAbort,
  output logic             oAbortAck,
`endif
  output logic             oInitRoundFlag,
  output logic             oFstRoundFlag,
  output logic             oMidRoundFlag,
  output logic             oLstRoundFlag,
  output logic [127:0]     oPlainText,
  output logic [127:0]     oAesKey,
  output logic             oBusy,
  output logic             oDone,
  output logic [127:0]     oCpText,
  output logic [CNT_W-1:0] oRoundCnt
);

  if (!(NUM_ROUNDS == 10 || NUM_ROUNDS == 12 || NUM_ROUNDS == 14)) begin : g_bad_rounds
    $fatal(1, "aes_round_ctrl: NUM_ROUNDS must be 10, 12 or 14");
  end
  if ((1 << CNT_W) <= NUM_ROUNDS) begin : g_bad_cnt_w
    $fatal(1, "aes_round_ctrl: CNT_W too narrow for NUM_ROUNDS");
  end

  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_TWO  = CNT_W'(2);
  // Last MID round index; reaching it moves to LST, which bounds the counter.
  localparam logic [CNT_W-1:0] LAST_MID = CNT_W'(NUM_ROUNDS - 1);
  localparam logic [CNT_W-1:0] LST_CNT  = CNT_W'(NUM_ROUNDS);

  typedef enum logic [2:0] {
    S_IDLE,
    S_INIT,
    S_FST,
    S_MID,
    S_LST,
    S_DONE
  } state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               init_q, fst_q, mid_q, lst_q;
  logic               busy_q, done_q;
  logic [127:0]       pt_q, key_q, cp_q;
  logic               accept;

  assign accept = (state_q == S_IDLE) && iStart;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      S_IDLE: begin
        if (iStart) begin
          state_d = S_INIT;
          cnt_d   = '0;
        end
      end
      S_INIT: begin
        state_d = S_FST;
        cnt_d   = CNT_ONE;
      end
      S_FST: begin
        state_d = S_MID;
        cnt_d   = CNT_TWO;
      end
      S_MID: begin
        if (cnt_q == LAST_MID) begin
          state_d = S_LST;
          cnt_d   = LST_CNT;
        end else begin
          cnt_d   = cnt_q + CNT_ONE;
        end
      end
      S_LST: begin
        state_d = S_DONE;
      end
      S_DONE: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase
`ifdef AES_ROUND_CTRL_ABORT_EN
    // Abort only cuts the round phases; DONE always runs to completion.
    if (iAbort && (state_q inside {S_INIT, S_FST, S_MID, S_LST})) begin
      state_d = S_IDLE;
      cnt_d   = '0;
    end
`endif
  end

  // Flags and busy are decoded from the next state so they are registered and
  // line up exactly with the state they describe.
  always_ff @(posedge iClk) begin
    if (iRsn) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      init_q  <= 1'b0;
      fst_q   <= 1'b0;
      mid_q   <= 1'b0;
      lst_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      pt_q    <= '0;
      key_q   <= '0;
      cp_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      init_q  <= (state_d == S_INIT);
      fst_q   <= (state_d == S_FST);
      mid_q   <= (state_d == S_MID);
      lst_q   <= (state_d == S_LST);
      busy_q  <= (state_d != S_IDLE);
      done_q  <= (state_q == S_DONE);
      if (accept) begin
        pt_q  <= iPlainText;
        key_q <= iAesKey;
      end
      if (state_q == S_DONE) begin
        cp_q  <= iCpText;
      end
    end
  end

`ifdef AES_ROUND_CTRL_ABORT_EN
  logic ack_q;
  always_ff @(posedge iClk) begin
    if (iRsn) begin
      ack_q <= 1'b0;
    end else begin
      ack_q <= iAbort && (state_q inside {S_INIT, S_FST, S_MID, S_LST});
    end
  end
  assign oAbortAck = ack_q;
`endif

  assign oInitRoundFlag = init_q;
  assign oFstRoundFlag  = fst_q;
  assign oMidRoundFlag  = mid_q;
  assign oLstRoundFlag  = lst_q;
  assign oBusy          = busy_q;
  assign oDone          = done_q;
  assign oPlainText     = pt_q;
  assign oAesKey        = key_q;
  assign oCpText        = cp_q;
  assign oRoundCnt      = cnt_q;

endmodule

// File: tb/tb_aes_round_ctrl.sv
// Bench for aes_round_ctrl: an AES-128 (10-round) and an AES-256 (14-round) instance share the
// same stimulus; each is compared every cycle against a model that tracks only "cycles since
// acceptance" and derives the expected flags, counter and data from that number.
module tb_aes_round_ctrl;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic         abort;
  logic [127:0] pt, key, cp;

  logic         f_init[2], f_fst[2], f_mid[2], f_lst[2];
  logic         busy_o[2], done_o[2];
  logic [127:0] pt_o[2], key_o[2], cp_o[2];
  logic [3:0]   cnt_o[2];
`ifdef AES_ROUND_CTRL_ABORT_EN
  logic         ack_o[2];
`endif

  always #5 clk = ~clk;

  aes_round_ctrl #(.NUM_ROUNDS(10), .CNT_W(4)) u_dut10 (
    .iClk(clk), .iRsn(rst), .iStart(start),
    .iPlainText(pt), .iAesKey(key), .iCpText(cp),
`ifdef AES_ROUND_CTRL_ABORT_EN
    .iAbort(abort), .oAbortAck(ack_o[0]),
`endif
    .oInitRoundFlag(f_init[0]), .oFstRoundFlag(f_fst[0]),
    .oMidRoundFlag(f_mid[0]), .oLstRoundFlag(f_lst[0]),
    .oPlainText(pt_o[0]), .oAesKey(key_o[0]),
    .oBusy(busy_o[0]), .oDone(done_o[0]),
    .oCpText(cp_o[0]), .oRoundCnt(cnt_o[0])
  );

  aes_round_ctrl #(.NUM_ROUNDS(14), .CNT_W(4)) u_dut14 (
    .iClk(clk), .iRsn(rst), .iStart(start),
    .iPlainText(pt), .iAesKey(key), .iCpText(cp),
`ifdef AES_ROUND_CTRL_ABORT_EN
    .iAbort(abort), .oAbortAck(ack_o[1]),
`endif
    .oInitRoundFlag(f_init[1]), .oFstRoundFlag(f_fst[1]),
    .oMidRoundFlag(f_mid[1]), .oLstRoundFlag(f_lst[1]),
    .oPlainText(pt_o[1]), .oAesKey(key_o[1]),
    .oBusy(busy_o[1]), .oDone(done_o[1]),
    .oCpText(cp_o[1]), .oRoundCnt(cnt_o[1])
  );

  // Reference model state: k = cycles since acceptance (0 = idle).
  int           mk[2];
  logic         mdone[2], mack[2];
  logic [127:0] mpt[2], mkey[2], mcp[2];
  int           nchecks = 0;
  int           nerr    = 0;

  function automatic int nr(input int i);
    return (i == 0) ? 10 : 14;
  endfunction

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    nchecks++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_edge();
    for (int i = 0; i < 2; i++) begin
      if (rst) begin
        mk[i] = 0; mdone[i] = 1'b0; mack[i] = 1'b0;
        mpt[i] = '0; mkey[i] = '0; mcp[i] = '0;
      end else begin
        mdone[i] = (mk[i] == nr(i) + 2);
        mack[i]  = 1'b0;
        if (mk[i] == nr(i) + 2) begin
          mcp[i] = cp;
          mk[i]  = 0;
        end else if (mk[i] == 0) begin
          if (start) begin
            mk[i] = 1; mpt[i] = pt; mkey[i] = key;
          end
        end else if (abort) begin
          mk[i] = 0; mack[i] = 1'b1;
        end else begin
          mk[i]++;
        end
      end
    end
  endtask

  task automatic check_all();
    for (int i = 0; i < 2; i++) begin
      int   n, k;
      logic [3:0] ef;
      logic [3:0] ecnt;
      string p;
      n = nr(i); k = mk[i];
      p = $sformatf("r%0d", n);
      ef = {k == 1, k == 2, (k >= 3) && (k <= n), k == n + 1};
      ecnt = (k == 0) ? 4'd0 : (k <= n + 1) ? 4'(k - 1) : 4'(n);
      chk({p, ".flags"}, {f_init[i], f_fst[i], f_mid[i], f_lst[i]}, ef);
      chk({p, ".onehot"}, ($countones({f_init[i], f_fst[i], f_mid[i], f_lst[i]}) <= 1), 1'b1);
      chk({p, ".busy"}, busy_o[i], k != 0);
      chk({p, ".done"}, done_o[i], mdone[i]);
      chk({p, ".cnt"}, cnt_o[i], ecnt);
      chk({p, ".pt"}, pt_o[i], mpt[i]);
      chk({p, ".key"}, key_o[i], mkey[i]);
      chk({p, ".cp"}, cp_o[i], mcp[i]);
`ifdef AES_ROUND_CTRL_ABORT_EN
      chk({p, ".ack"}, ack_o[i], mack[i]);
`endif
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    check_all();
  endtask

  initial begin
    int busy_cnt, done_at, done_at14, mid_cnt10, mid_cnt14, peak14, dones;
    logic [127:0] first_pt;
    for (int i = 0; i < 2; i++) begin
      mk[i] = 0; mdone[i] = 0; mack[i] = 0; mpt[i] = '0; mkey[i] = '0; mcp[i] = '0;
    end
    rst = 1'b1; start = 1'b0; abort = 1'b0;
    pt = '0; key = '0; cp = '0;
    step(); step();
    rst = 1'b0;
    step();

    // FIPS-197 AES-128 vector through both instances.
    pt  = 128'h00112233445566778899aabbccddeeff;
    key = 128'h000102030405060708090a0b0c0d0e0f;
    cp  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    start = 1'b1;
    busy_cnt = 0; done_at = 0; done_at14 = 0; mid_cnt10 = 0; mid_cnt14 = 0; peak14 = 0;
    for (int c = 1; c <= 19; c++) begin
      step();
      if (c == 1) start = 1'b0;
      if (busy_o[0]) busy_cnt++;
      if (f_mid[0]) mid_cnt10++;
      if (f_mid[1]) mid_cnt14++;
      if (done_o[0]) done_at = c;
      if (done_o[1]) done_at14 = c;
      if (int'(cnt_o[1]) > peak14) peak14 = int'(cnt_o[1]);
    end
    chk("t1.busy_cycles", busy_cnt, 12);
    chk("t1.done_cycle", done_at, 13);
    chk("t1.mid_cycles", mid_cnt10, 8);
    chk("t1.ciphertext", cp_o[0], 128'h69c4e0d86a7b0430d8cdb78070b4c55a);
    chk("r14.done_cycle", done_at14, 17);
    chk("r14.mid_cycles", mid_cnt14, 12);
    chk("r14.cnt_peak", peak14, 14);

    // Start while busy must be ignored.
    first_pt = rnd128();
    pt = first_pt; key = rnd128(); start = 1'b1;
    done_at = 0;
    for (int c = 1; c <= 19; c++) begin
      step();
      start = 1'b0;
      cp = rnd128();
      if (c == 4) begin
        start = 1'b1; pt = rnd128(); key = rnd128();
      end
      if (done_o[0]) done_at = c;
    end
    chk("busy_start.pt", pt_o[0], first_pt);
    chk("busy_start.done_cycle", done_at, 13);

    // Back-to-back with start held high.
    start = 1'b1;
    dones = 0;
    for (int c = 0; c < 45; c++) begin
      pt = rnd128(); key = rnd128(); cp = rnd128();
      step();
      if (done_o[0]) dones++;
    end
    chk("b2b.done_count", dones, 3);
    start = 1'b0;
    for (int c = 0; c < 18; c++) step();

    // Reset during MID with round counter at 5.
    cp = rnd128(); pt = rnd128(); key = rnd128();
    start = 1'b1;
    for (int c = 1; c <= 6; c++) begin
      step();
      start = 1'b0;
    end
    chk("rst.cnt_before", cnt_o[0], 4'd5);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("rst.flags", {f_init[0], f_fst[0], f_mid[0], f_lst[0]}, 4'b0000);
    chk("rst.busy", busy_o[0], 1'b0);
    chk("rst.cp", cp_o[0], 128'h0);
    dones = 0;
    for (int c = 0; c < 20; c++) begin
      step();
      if (done_o[0] || done_o[1]) dones++;
    end
    chk("rst.no_done", dones, 0);

`ifdef AES_ROUND_CTRL_ABORT_EN
    // Complete one op so there is a ciphertext to retain, then abort at cnt=3.
    cp = rnd128(); start = 1'b1;
    for (int c = 1; c <= 18; c++) begin
      step();
      start = 1'b0;
    end
    start = 1'b1; pt = rnd128();
    for (int c = 1; c <= 4; c++) begin
      step();
      start = 1'b0;
    end
    chk("abort.cnt_before", cnt_o[0], 4'd3);
    abort = 1'b1;
    step();
    abort = 1'b0;
    chk("abort.busy", busy_o[0], 1'b0);
    chk("abort.ack", ack_o[0], 1'b1);
    dones = 0;
    for (int c = 0; c < 20; c++) begin
      step();
      if (done_o[0]) dones++;
    end
    chk("abort.no_done", dones, 0);
`endif

    // Random traffic.
    for (int c = 0; c < 600; c++) begin
      start = ($urandom_range(3) == 0);
      pt = rnd128(); key = rnd128(); cp = rnd128();
`ifdef AES_ROUND_CTRL_ABORT_EN
      abort = ($urandom_range(11) == 0);
`endif
      rst = ($urandom_range(120) == 0);
      step();
    end
    rst = 1'b0; start = 1'b0; abort = 1'b0;
    for (int c = 0; c < 20; c++) step();

    $display("Simulation finished: %0d checks, %0d errors", nchecks, nerr);
    $finish;
  end

endmodule
